lb_chan_read_pipe: RTL and testbench
====================================

Name: lb_chan_read_pipe

Overview:
- Local-bus fan-out and read-return block that sits behind mem_gateway, in the Ethernet/local-bus clock domain.
- Decodes each gateway transaction onto one of NCH register channels and issues registered per-channel strobes.
- Collects the selected channel's read word after a fixed channel latency.
- Returns that word on lb_data_in exactly READ_PIPE_LEN cycles after the gateway strobe, matching the gateway's read_pipe_len.
- Replaces hand-built address-case muxes and strobe delay chains with one fully pipelined, parametrised unit.

Parameters:
- NCH, 4, number of register channels (1..2**CH_SEL_W).
- AW, 24, local-bus address width.
- DW, 32, data width.
- CH_SEL_LSB, 20, LSB of the channel-select field in lb_addr.
- CH_SEL_W, 4, width of the channel-select field.
- CH_LAT, 1, cycles from ch_strobe to valid ch_rdata.
- READ_PIPE_LEN, 11, cycles from lb_strobe to lb_data_in valid; must be >= CH_LAT+2.
- DEFAULT_WORD, 32'hdeadbeef, read value for an unmapped channel index.

Ports:
- clk  in  1  local-bus clock.
- rst  in  1  synchronous, active-high reset.
- lb_strobe  in  1  transaction strobe from the gateway, one cycle per transaction.
- lb_rd  in  1  1=read, 0=write; qualified by lb_strobe.
- lb_addr  in  AW  transaction address.
- lb_wdata  in  DW  write data.
- lb_data_in  out  DW  read data returned to the gateway.
- lb_rvalid  out  1  single-cycle pulse marking lb_data_in update.
- ch_strobe  out  NCH  one-hot per-channel strobe.
- ch_rd  out  1  registered copy of lb_rd.
- ch_addr  out  CH_SEL_LSB  registered lb_addr[CH_SEL_LSB-1:0].
- ch_wdata  out  DW  registered write data.
- ch_rdata  in  NCH*DW  channel read data; channel k occupies [k*DW+:DW].

Behaviour:
- Reset values: lb_data_in=0, lb_rvalid=0, ch_strobe=0, ch_rd=0, ch_addr=0, ch_wdata=0. All pipeline valid bits are cleared.
- Define sel = lb_addr[CH_SEL_LSB+:CH_SEL_W], and T = the cycle in which lb_strobe=1.
- Cycle T+1:
  - ch_strobe[sel]=1 if sel<NCH, otherwise all zeros.
  - ch_rd, ch_addr and ch_wdata are loaded.
  - These loads occur on every strobe, reads and writes alike.
- Read capture: at T+1+CH_LAT, the block captures ch_rdata[sel], or DEFAULT_WORD if sel>=NCH, into a pipeline stage tagged with the read flag.
- Read return: the captured word is delayed so that lb_data_in updates and lb_rvalid=1 at exactly T+READ_PIPE_LEN.
- Writes never update lb_data_in and never assert lb_rvalid; lb_data_in holds the last read result.
- Throughput: one strobe per cycle with no bubbles. Each in-flight transaction has its own sel/rd tag, carried through a shift register of depth READ_PIPE_LEN. No handshake or backpressure.
- Back-to-back reads to different channels return in issue order, one per cycle.
- Mixed sequences such as read, write, read produce rvalid pulses only for the reads, at their own T+READ_PIPE_LEN.
- Reset mid-operation discards all in-flight transactions: no lb_rvalid is asserted for strobes accepted before the reset. The first strobe after reset deasserts behaves normally.
- lb_strobe asserted while rst=1 is ignored.
- Addresses above the select field (bits >= CH_SEL_LSB+CH_SEL_W) are ignored.
- Elaboration checks: READ_PIPE_LEN<CH_LAT+2 or NCH>2**CH_SEL_W is a $error.

Optional Feature:
- Macro: LB_ACCESS_CNT_EN.
- Defined:
  - Two 16-bit saturating counters, rd_cnt and wr_cnt, increment on each accepted read or write strobe. A counter that has reached 16'hffff stays there.
  - A read with sel == 2**CH_SEL_W-1 returns {rd_cnt, wr_cnt} instead of DEFAULT_WORD, sampled at the capture stage. This requires NCH < 2**CH_SEL_W.
  - A write to that index clears both counters at T+1.
  - The counted transaction includes itself.
  - rst clears both counters.
- Not defined: that index behaves as any other unmapped channel, and no counters exist.

Decomposition:
- Package lb_pipe_pkg: DW/AW defaults, DEFAULT_WORD, the counter index constant, and a tag struct {valid, rd, sel}.
- One natural sub-module: lb_tag_delay, a parametrised-depth valid/tag shift register with synchronous clear. Instantiate it for the capture alignment and for the return alignment.

Test Plan:
- Setup: NCH=4, CH_LAT=1, READ_PIPE_LEN=11. Channels return "Hell", "o wo", "rld!", "(::)" on indices 0..3.
  - Single read addr=24'h100000 -> ch_strobe=4'b0010 at T+1; lb_data_in="o wo" with lb_rvalid at T+11.
  - Four back-to-back reads of sel 0,1,2,3 -> four consecutive rvalid cycles carrying "Hell", "o wo", "rld!", "(::)" in order.
  - Read sel=5 -> ch_strobe=0; lb_data_in=32'hdeadbeef at T+11.
  - Sequence read(0), write(2, 32'h11223344), read(3) -> ch_wdata=32'h11223344 with ch_strobe=4'b0100 at T+1 of the write; rvalid only for the two reads, with values "Hell" and "(::)".
- Reset mid-operation: rst pulsed at T+5 after a read -> no lb_rvalid; lb_data_in=0.
- With LB_ACCESS_CNT_EN: 3 reads + 2 writes, then read sel=15 -> lb_data_in=32'h0004_0002 (the counter read counts itself); write to sel=15, then read sel=15 -> 32'h0001_0000.

Source files
------------

// File: rtl/lb_pipe_pkg.sv
// Shared constants and the in-flight transaction tag for lb_chan_read_pipe.
// The LB_ACCESS_CNT_EN build uses cnt_sel() to locate the access-counter index.
package lb_pipe_pkg;

    localparam int          LB_AW           = 24;
    localparam int          LB_DW           = 32;
    localparam int          LB_CH_SEL_W     = 4;
    localparam logic [31:0] LB_DEFAULT_WORD = 32'hdeadbeef;

    // Tag sel is sized for the widest supported select field; narrower fields zero-extend.
    localparam int SEL_MAX_W = 8;
    typedef logic [SEL_MAX_W-1:0] sel_t;

    typedef struct packed {
        logic valid;
        logic rd;
        sel_t sel;
    } tag_t;

    function automatic sel_t cnt_sel(input int w);
        return sel_t'((1 << w) - 1);
    endfunction

    localparam sel_t LB_CNT_SEL = cnt_sel(LB_CH_SEL_W);

endpackage

// File: rtl/lb_tag_delay.sv
// Fixed-depth shift register for transaction tags; rst clears every stage.
// A depth of 0 gives a straight wire from tag_in to tag_out.
module lb_tag_delay
    import lb_pipe_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign tag_out = tag_in;
        end else begin : g_sr
            tag_t tag_q [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
                end else begin
                    tag_q[0] <= tag_in;
                    for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
                end
            end

            assign tag_out = tag_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/lb_chan_read_pipe.sv
// Local-bus fan-out to NCH channels with a fixed-latency read return.
// Optional macro LB_ACCESS_CNT_EN adds read/write access counters at the top channel index.
module lb_chan_read_pipe
    import lb_pipe_pkg::*;
#(
    parameter int NCH           = 4,
    parameter int AW            = LB_AW,
    parameter int DW            = LB_DW,
    parameter int CH_SEL_LSB    = 20,
    parameter int CH_SEL_W      = LB_CH_SEL_W,
    parameter int CH_LAT        = 1,
    parameter int READ_PIPE_LEN = 11,
    parameter logic [DW-1:0] DEFAULT_WORD = DW'(LB_DEFAULT_WORD)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lb_strobe,
    input  logic                  lb_rd,
    input  logic [AW-1:0]         lb_addr,
    input  logic [DW-1:0]         lb_wdata,
    output logic [DW-1:0]         lb_data_in,
    output logic                  lb_rvalid,
    output logic [NCH-1:0]        ch_strobe,
    output logic                  ch_rd,
    output logic [CH_SEL_LSB-1:0] ch_addr,
    output logic [DW-1:0]         ch_wdata,
    input  logic [NCH*DW-1:0]     ch_rdata
);

    // Stages between the capture mux and the output register.
    localparam int RET_D = (READ_PIPE_LEN >= CH_LAT + 2) ? READ_PIPE_LEN - CH_LAT - 2 : 0;

    generate
        if (READ_PIPE_LEN < CH_LAT + 2) begin : g_chk_len
            $error("lb_chan_read_pipe: READ_PIPE_LEN must be >= CH_LAT+2");
        end
        if (NCH < 1 || NCH > 2**CH_SEL_W || CH_SEL_W > SEL_MAX_W) begin : g_chk_nch
            $error("lb_chan_read_pipe: NCH must be 1..2**CH_SEL_W, CH_SEL_W <= SEL_MAX_W");
        end
    endgenerate

    sel_t           sel;
    logic [NCH-1:0] strobe_nxt;
    tag_t           s0_tag, cap_tag, ret_tag;
    logic [DW-1:0]  cap_word, ret_data;

    assign sel = sel_t'(lb_addr[CH_SEL_LSB +: CH_SEL_W]);

    always_comb begin
        strobe_nxt = '0;
        for (int k = 0; k < NCH; k++)
            if (lb_strobe && sel == sel_t'(k)) strobe_nxt[k] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_strobe <= '0;
            ch_rd     <= 1'b0;
            ch_addr   <= '0;
            ch_wdata  <= '0;
            s0_tag    <= '0;
        end else begin
            ch_strobe    <= strobe_nxt;
            s0_tag.valid <= lb_strobe;
            s0_tag.rd    <= lb_rd;
            s0_tag.sel   <= sel;
            if (lb_strobe) begin
                ch_rd    <= lb_rd;
                ch_addr  <= lb_addr[CH_SEL_LSB-1:0];
                ch_wdata <= lb_wdata;
            end
        end
    end

`ifdef LB_ACCESS_CNT_EN
    localparam sel_t CNT_SEL = cnt_sel(CH_SEL_W);

    generate
        if (NCH >= 2**CH_SEL_W) begin : g_chk_cnt
            $error("lb_chan_read_pipe: LB_ACCESS_CNT_EN needs NCH < 2**CH_SEL_W");
        end
    endgenerate

    logic [15:0] rd_cnt, wr_cnt;

    // A write to the counter index clears instead of counting itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (lb_strobe) begin
            if (!lb_rd && sel == CNT_SEL) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else if (lb_rd) begin
                if (rd_cnt != 16'hffff) rd_cnt <= rd_cnt + 16'd1;
            end else begin
                if (wr_cnt != 16'hffff) wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end
`endif

    lb_tag_delay #(.DEPTH(CH_LAT)) u_cap_dly (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (s0_tag),
        .tag_out (cap_tag)
    );

    always_comb begin
        cap_word = DEFAULT_WORD;
`ifdef LB_ACCESS_CNT_EN
        if (cap_tag.sel == CNT_SEL) cap_word = DW'({rd_cnt, wr_cnt});
`endif
        for (int k = 0; k < NCH; k++)
            if (cap_tag.sel == sel_t'(k)) cap_word = ch_rdata[k*DW +: DW];
    end

    lb_tag_delay #(.DEPTH(RET_D)) u_ret_dly (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (cap_tag),
        .tag_out (ret_tag)
    );

    // Data rides alongside the return tags; only the tag stages need clearing.
    generate
        if (RET_D == 0) begin : g_dpass
            assign ret_data = cap_word;
        end else begin : g_dsr
            logic [DW-1:0] d_q [RET_D];
            always_ff @(posedge clk) begin
                d_q[0] <= cap_word;
                for (int i = 1; i < RET_D; i++) d_q[i] <= d_q[i-1];
            end
            assign ret_data = d_q[RET_D-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            lb_data_in <= '0;
            lb_rvalid  <= 1'b0;
        end else begin
            lb_rvalid <= ret_tag.valid && ret_tag.rd;
            if (ret_tag.valid && ret_tag.rd) lb_data_in <= ret_data;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{lb_addr, ret_tag.sel};

endmodule

// File: tb/tb_lb_chan_read_pipe.sv
// Scoreboard bench for lb_chan_read_pipe; define LB_ACCESS_CNT_EN to also cover the counters.
module tb_lb_chan_read_pipe;

    localparam int RPL = 11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         lb_strobe = 1'b0;
    logic         lb_rd = 1'b0;
    logic [23:0]  lb_addr = '0;
    logic [31:0]  lb_wdata = '0;
    logic [31:0]  lb_data_in;
    logic         lb_rvalid;
    logic [3:0]   ch_strobe;
    logic         ch_rd;
    logic [19:0]  ch_addr;
    logic [31:0]  ch_wdata;
    logic [127:0] ch_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q [$];

    lb_chan_read_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .lb_strobe  (lb_strobe),
        .lb_rd      (lb_rd),
        .lb_addr    (lb_addr),
        .lb_wdata   (lb_wdata),
        .lb_data_in (lb_data_in),
        .lb_rvalid  (lb_rvalid),
        .ch_strobe  (ch_strobe),
        .ch_rd      (ch_rd),
        .ch_addr    (ch_addr),
        .ch_wdata   (ch_wdata),
        .ch_rdata   (ch_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_of(input int k);
        case (k)
            0: return "Hell";
            1: return "o wo";
            2: return "rld!";
            default: return "(::)";
        endcase
    endfunction

    // Channel model: read word valid exactly one cycle after its strobe, junk otherwise.
    logic [31:0] ch_q [4];
    always @(posedge clk)
        for (int k = 0; k < 4; k++)
            ch_q[k] <= ch_strobe[k] ? word_of(k) : (32'h0bad0000 + 32'(k));
    assign ch_rdata = {ch_q[3], ch_q[2], ch_q[1], ch_q[0]};

    // Every rvalid must match the oldest expected read, at its exact cycle.
    always @(negedge clk) begin
        if (lb_rvalid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rvalid cyc=%0d data=%h required none", cyc, lb_data_in);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cyc !== e.cyc || lb_data_in !== e.data) begin
                    n_fail++;
                    $display("FAIL rdata cyc=%0d data=%h required cyc=%0d data=%h",
                             cyc, lb_data_in, e.cyc, e.data);
                end
            end
        end
    end

    // Called just after a negedge; returns at the negedge of T+1.
    task automatic issue(input bit rd, input int ch, input logic [19:0] low,
                         input logic [31:0] wd, input logic [31:0] expv);
        exp_t e;
        lb_strobe = 1'b1;
        lb_rd     = rd;
        lb_addr   = {4'(ch), low};
        lb_wdata  = wd;
        if (rd) begin
            e.cyc  = cyc + RPL;
            e.data = expv;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic wait_drain();
        lb_strobe = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (lb_data_in !== 32'h0) begin n_fail++; $display("FAIL rst_data got=%h exp=0", lb_data_in); end
        n_checks++; if (lb_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got=%b exp=0", lb_rvalid); end
        n_checks++; if (ch_strobe !== 4'b0) begin n_fail++; $display("FAIL rst_strobe got=%b exp=0", ch_strobe); end
        n_checks++; if (ch_rd !== 1'b0) begin n_fail++; $display("FAIL rst_rd got=%b exp=0", ch_rd); end
        n_checks++; if (ch_addr !== 20'h0) begin n_fail++; $display("FAIL rst_addr got=%h exp=0", ch_addr); end
        n_checks++; if (ch_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got=%h exp=0", ch_wdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        issue(1'b1, 1, 20'h00000, 32'h0, word_of(1));
        lb_strobe = 1'b0;
        n_checks++; if (ch_strobe !== 4'b0010) begin n_fail++; $display("FAIL single_strobe got=%b exp=0010", ch_strobe); end
        n_checks++; if (ch_rd !== 1'b1) begin n_fail++; $display("FAIL single_rd got=%b exp=1", ch_rd); end
        @(negedge clk);
        n_checks++; if (ch_strobe !== 4'b0000) begin n_fail++; $display("FAIL single_strobe_pulse got=%b exp=0000", ch_strobe); end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) issue(1'b1, k, 20'h00010, 32'h0, word_of(k));
        wait_drain();
        n_checks++; if (lb_data_in !== word_of(3)) begin n_fail++; $display("FAIL b2b_hold got=%h exp=%h", lb_data_in, word_of(3)); end
    endtask

    task automatic test_unmapped();
        issue(1'b1, 5, 20'h00000, 32'h0, 32'hdeadbeef);
        lb_strobe = 1'b0;
        n_checks++; if (ch_strobe !== 4'b0) begin n_fail++; $display("FAIL unmapped_strobe got=%b exp=0", ch_strobe); end
        wait_drain();
    endtask

    task automatic test_addr_fields();
        issue(1'b1, 2, 20'habcde, 32'h0, word_of(2));
        lb_strobe = 1'b0;
        n_checks++; if (ch_addr !== 20'habcde) begin n_fail++; $display("FAIL ch_addr got=%h exp=abcde", ch_addr); end
        n_checks++; if (ch_strobe !== 4'b0100) begin n_fail++; $display("FAIL addr_strobe got=%b exp=0100", ch_strobe); end
        wait_drain();
    endtask

    task automatic test_mixed();
        issue(1'b1, 0, 20'h00000, 32'h0, word_of(0));
        issue(1'b0, 2, 20'h00004, 32'h11223344, 32'h0);
        n_checks++; if (ch_wdata !== 32'h11223344) begin n_fail++; $display("FAIL mixed_wdata got=%h exp=11223344", ch_wdata); end
        n_checks++; if (ch_strobe !== 4'b0100) begin n_fail++; $display("FAIL mixed_strobe got=%b exp=0100", ch_strobe); end
        n_checks++; if (ch_rd !== 1'b0) begin n_fail++; $display("FAIL mixed_rd got=%b exp=0", ch_rd); end
        issue(1'b1, 3, 20'h00000, 32'h0, word_of(3));
        wait_drain();
        // A trailing write must leave the last read word in place.
        issue(1'b0, 1, 20'h0, 32'h55aa55aa, 32'h0);
        repeat (RPL + 2) @(negedge clk);
        lb_strobe = 1'b0;
        n_checks++; if (lb_data_in !== word_of(3)) begin n_fail++; $display("FAIL write_hold got=%h exp=%h", lb_data_in, word_of(3)); end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 1, 20'h0, 32'h0, word_of(1));
        lb_strobe = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        lb_strobe = 1'b1;
        lb_rd     = 1'b1;
        lb_addr   = 24'h000000;
        @(negedge clk);
        rst = 1'b0;
        lb_strobe = 1'b0;
        n_checks++; if (ch_strobe !== 4'b0) begin n_fail++; $display("FAIL rst_strobe_ignored got=%b exp=0", ch_strobe); end
        repeat (RPL + 4) @(negedge clk);
        n_checks++; if (lb_data_in !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data got=%h exp=0", lb_data_in); end
        issue(1'b1, 3, 20'h0, 32'h0, word_of(3));
        wait_drain();
    endtask

`ifdef LB_ACCESS_CNT_EN
    task automatic test_counters();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) issue(1'b1, k, 20'h0, 32'h0, word_of(k));
        issue(1'b0, 0, 20'h0, 32'h1, 32'h0);
        issue(1'b0, 1, 20'h0, 32'h2, 32'h0);
        issue(1'b1, 15, 20'h0, 32'h0, 32'h0004_0002);
        wait_drain();
        issue(1'b0, 15, 20'h0, 32'h0, 32'h0);
        issue(1'b1, 15, 20'h0, 32'h0, 32'h0001_0000);
        wait_drain();
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_single_read();
        test_back_to_back();
        test_unmapped();
        test_addr_fields();
        test_mixed();
        test_reset_mid();
`ifdef LB_ACCESS_CNT_EN
        test_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
